// File: rtl/mlp_pkg.sv
// Shared constants and types for the MNIST MLP layer-2 datapath.
// Lane 0 always sits in the most significant slice of any packed lane vector.
package mlp_pkg;

    localparam int ROWS   = 32;
    localparam int LANES  = 10;
    localparam int W_W    = 16;
    localparam int ACC_W  = 40;
    localparam int ADDR_W = 6;
    localparam int IDX_W  = 4;

    typedef logic signed [W_W-1:0]   weight_t;
    typedef logic signed [ACC_W-1:0] acc_t;

    typedef enum logic [2:0] {
        IDLE,
        READ,
        DRAIN,
        ARGMAX,
        DONE
    } seq_state_t;

endpackage

// File: rtl/argmax_seq.sv
// Sequential signed argmax over LANES accumulators, one lane per clock.
// A lane replaces the current best only when it is strictly greater, so ties keep the lowest index.
module argmax_seq
    import mlp_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [LANES*ACC_W-1:0] vals,
    output logic                   done,
    output logic [IDX_W-1:0]       idx
);

    acc_t             lane [LANES];
    acc_t             best;
    logic [IDX_W-1:0] cnt;
    logic             running;

    for (genvar j = 0; j < LANES; j++) begin : g_unpack
        assign lane[j] = vals[LANES*ACC_W-1-j*ACC_W -: ACC_W];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            best    <= '0;
            idx     <= '0;
            cnt     <= '0;
            running <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start) begin
                best    <= lane[0];
                idx     <= '0;
                cnt     <= IDX_W'(1);
                running <= 1'b1;
            end else if (running) begin
                if (lane[cnt] > best) begin
                    best <= lane[cnt];
                    idx  <= cnt;
                end
                if (cnt == IDX_W'(LANES-1)) begin
                    running <= 1'b0;
                    done    <= 1'b1;
                end else begin
                    cnt <= cnt + IDX_W'(1);
                end
            end
        end
    end

endmodule

// File: rtl/layer2_mac_sequencer.sv
// Layer-2 sequencer: streams 32 weight/activation rows through 10 signed MAC lanes,
// then runs an argmax over the resulting logits and publishes the winning class.
module layer2_mac_sequencer
    import mlp_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    output logic                   busy,
    output logic                   done,
    output logic [ADDR_W-1:0]      rd_addr,
    input  logic [LANES*W_W-1:0]   w_data,
    input  logic [W_W-1:0]         act_data,
    output logic [LANES*ACC_W-1:0] logits,
    output logic [IDX_W-1:0]       class_idx,
    output logic                   class_valid
);

    seq_state_t       state;
    logic             addr_v;
    logic             data_v;
    logic             am_start;
    logic             am_done;
    logic [IDX_W-1:0] am_idx;
    logic             clear_acc;
    weight_t          act_s;
    acc_t             acc  [LANES];
    acc_t             term [LANES];

    assign clear_acc = (state == IDLE) && start;
    assign act_s     = act_data;

    // Full 32-bit signed product per lane, sign-extended to the accumulator width.
    for (genvar j = 0; j < LANES; j++) begin : g_lane
        weight_t                 w_j;
        logic signed [2*W_W-1:0] prod_j;
        assign w_j     = w_data[LANES*W_W-1-j*W_W -: W_W];
        assign prod_j  = w_j * act_s;
        assign term[j] = {{(ACC_W-2*W_W){prod_j[2*W_W-1]}}, prod_j};
        assign logits[LANES*ACC_W-1-j*ACC_W -: ACC_W] = acc[j];
    end

    always_ff @(posedge clk) begin
        if (rst || clear_acc) begin
            for (int j = 0; j < LANES; j++) acc[j] <= '0;
        end else if (data_v) begin
            for (int j = 0; j < LANES; j++) acc[j] <= acc[j] + term[j];
        end
    end

    // addr_v marks a live address this cycle; data_v follows it by the BRAM read latency.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
            class_valid <= 1'b0;
            class_idx   <= '0;
            rd_addr     <= '0;
            addr_v      <= 1'b0;
            data_v      <= 1'b0;
            am_start    <= 1'b0;
        end else begin
            done     <= 1'b0;
            am_start <= 1'b0;
            data_v   <= addr_v;
            case (state)
                IDLE: begin
                    if (start) begin
                        busy        <= 1'b1;
                        class_valid <= 1'b0;
                        rd_addr     <= '0;
                        addr_v      <= 1'b1;
                        state       <= READ;
                    end
                end
                READ: begin
                    rd_addr <= rd_addr + ADDR_W'(1);
                    if (rd_addr == ADDR_W'(ROWS-2)) state <= DRAIN;
                end
                DRAIN: begin
                    addr_v <= 1'b0;
                    if (!addr_v && data_v) begin
                        am_start <= 1'b1;
                        state    <= ARGMAX;
                    end
                end
                ARGMAX: begin
                    if (am_done) begin
                        class_idx   <= am_idx;
                        class_valid <= 1'b1;
                        done        <= 1'b1;
                        busy        <= 1'b0;
                        state       <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    argmax_seq u_argmax (
        .clk   (clk),
        .rst   (rst),
        .start (am_start),
        .vals  (logits),
        .done  (am_done),
        .idx   (am_idx)
    );

endmodule

// File: tb/tb_layer2_mac_sequencer.sv
// Self-checking bench: random weight BRAM and activation memory, behavioural dot-product/argmax model.
module tb_layer2_mac_sequencer;
    import mlp_pkg::*;

    logic                   clk;
    logic                   rst;
    logic                   start;
    logic                   busy;
    logic                   done;
    logic [ADDR_W-1:0]      rd_addr;
    logic [LANES*W_W-1:0]   w_data;
    logic [W_W-1:0]         act_data;
    logic [LANES*ACC_W-1:0] logits;
    logic [IDX_W-1:0]       class_idx;
    logic                   class_valid;

    logic signed [W_W-1:0] wt      [ROWS][LANES];
    logic signed [W_W-1:0] act_mem [ROWS];
    logic [63:0]           exp_q[$];
    longint                last_exp [LANES];
    int                    n_checks = 0;
    int                    n_errors = 0;
    int                    max_addr = 0;

    layer2_mac_sequencer dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .busy        (busy),
        .done        (done),
        .rd_addr     (rd_addr),
        .w_data      (w_data),
        .act_data    (act_data),
        .logits      (logits),
        .class_idx   (class_idx),
        .class_valid (class_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [LANES*W_W-1:0] pack_row(input int r);
        logic [LANES*W_W-1:0] v;
        v = '0;
        for (int j = 0; j < LANES; j++) v[LANES*W_W-1-j*W_W -: W_W] = wt[r][j];
        return v;
    endfunction

    // Registered-read memories shared by one address bus.
    always @(posedge clk) begin
        w_data   <= pack_row(int'(rd_addr[4:0]));
        act_data <= act_mem[rd_addr[4:0]];
    end

    task automatic check(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic model_push();
        longint s;
        longint best;
        int     bi;
        best = 0;
        bi   = 0;
        for (int j = 0; j < LANES; j++) begin
            s = 0;
            for (int r = 0; r < ROWS; r++) s += longint'(wt[r][j]) * longint'(act_mem[r]);
            exp_q.push_back(s);
            last_exp[j] = s;
            if (j == 0 || s > best) begin
                best = s;
                bi   = j;
            end
        end
        exp_q.push_back(64'(bi));
    endtask

    task automatic fill_weights_random();
        for (int r = 0; r < ROWS; r++)
            for (int j = 0; j < LANES; j++) wt[r][j] = W_W'($urandom);
    endtask

    task automatic set_acts_zero();
        for (int r = 0; r < ROWS; r++) act_mem[r] = '0;
    endtask

    task automatic set_acts_random();
        for (int r = 0; r < ROWS; r++) act_mem[r] = W_W'($urandom);
    endtask

    task automatic check_logits(input string name);
        acc_t   lv;
        longint e;
        for (int j = 0; j < LANES; j++) begin
            lv = logits[LANES*ACC_W-1-j*ACC_W -: ACC_W];
            e  = longint'(exp_q.pop_front());
            check($sformatf("%s_lane%0d", name, j), longint'(lv), e);
        end
    endtask

    // mode 0: plain run, 1: start pulses while busy, 2: reset at cycle 15.
    task automatic run_inference(input string name, input int mode, input int exp_acc);
        int n;
        int cyc;
        bit busy_bad;
        model_push();
        start = 1'b1;
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!busy && n < 8);
        start = 1'b0;
        check({name, "_accept_edges"}, n, exp_acc);
        if (!busy) begin
            exp_q.delete();
            return;
        end
        check({name, "_accept_addr"}, longint'(rd_addr), 0);
        check({name, "_accept_cv"}, longint'(class_valid), 0);
        check({name, "_accept_cleared"}, longint'(logits != '0), 0);
        cyc = 0;
        busy_bad = 1'b0;
        while (cyc < 100) begin
            @(posedge clk); #1;
            cyc++;
            if (mode == 2 && cyc == 15) begin
                rst = 1'b1;
                @(posedge clk); #1;
                check({name, "_rst_busy"}, longint'(busy), 0);
                check({name, "_rst_done"}, longint'(done), 0);
                check({name, "_rst_cv"}, longint'(class_valid), 0);
                check({name, "_rst_addr"}, longint'(rd_addr), 0);
                check({name, "_rst_logits"}, longint'(logits != '0), 0);
                rst = 1'b0;
                exp_q.delete();
                return;
            end
            if (done) break;
            if (!busy) busy_bad = 1'b1;
            if (int'(rd_addr) > max_addr) max_addr = int'(rd_addr);
            if (cyc == 1 || cyc == 20 || cyc == 40)
                check($sformatf("%s_addr_c%0d", name, cyc), longint'(rd_addr), (cyc < ROWS) ? cyc : ROWS-1);
            if (mode == 1) start = (cyc == 5 || cyc == 20);
        end
        start = 1'b0;
        if (!done) begin
            check({name, "_done_timeout"}, cyc, ROWS+LANES+2);
            exp_q.delete();
            return;
        end
        check({name, "_latency"}, cyc, ROWS+LANES+2);
        check({name, "_busy_through"}, longint'(busy_bad), 0);
        check({name, "_busy_at_done"}, longint'(busy), 0);
        check({name, "_cv_at_done"}, longint'(class_valid), 1);
        check_logits(name);
        check({name, "_class"}, longint'(class_idx), longint'(exp_q.pop_front()));
    endtask

    task automatic post_done(input string name);
        acc_t lv;
        @(posedge clk); #1;
        check({name, "_done_pulse"}, longint'(done), 0);
        check({name, "_cv_hold"}, longint'(class_valid), 1);
        lv = logits[LANES*ACC_W-1 -: ACC_W];
        check({name, "_hold_lane0"}, longint'(lv), last_exp[0]);
        lv = logits[ACC_W-1:0];
        check({name, "_hold_lane9"}, longint'(lv), last_exp[LANES-1]);
    endtask

    task automatic quiet(input string name);
        int dones;
        int busys;
        dones = 0;
        busys = 0;
        repeat (50) begin
            @(posedge clk); #1;
            if (done) dones++;
            if (busy) busys++;
        end
        check({name, "_extra_done"}, dones, 0);
        check({name, "_extra_busy"}, busys, 0);
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        fill_weights_random();
        set_acts_zero();
        repeat (3) @(posedge clk);
        #1;
        check("reset_busy", longint'(busy), 0);
        check("reset_done", longint'(done), 0);
        check("reset_cv", longint'(class_valid), 0);
        check("reset_addr", longint'(rd_addr), 0);
        check("reset_class", longint'(class_idx), 0);
        check("reset_logits", longint'(logits != '0), 0);
        rst = 1'b0;
        @(posedge clk); #1;

        run_inference("zero_act", 0, 1);
        post_done("zero_act");

        set_acts_zero();
        act_mem[0] = 16'sd1;
        run_inference("row0_pos", 0, 1);
        post_done("row0_pos");

        act_mem[0] = -16'sd1;
        run_inference("row0_neg", 0, 1);
        post_done("row0_neg");

        set_acts_zero();
        act_mem[3] = 16'sd2;
        run_inference("row3_x2", 0, 1);
        post_done("row3_x2");

        set_acts_zero();
        act_mem[0] = 16'sd1;
        for (int j = 0; j < LANES; j++) wt[0][j] = W_W'($urandom_range(2000) - 1000);
        wt[0][2] = 16'sh7fff;
        wt[0][6] = 16'sh7fff;
        run_inference("tie", 0, 1);
        post_done("tie");

        for (int r = 0; r < ROWS; r++) begin
            act_mem[r] = 16'sh8000;
            for (int j = 0; j < LANES; j++) wt[r][j] = (j == 4) ? 16'sh7fff : 16'sh8000;
        end
        run_inference("extreme", 0, 1);
        post_done("extreme");

        fill_weights_random();
        set_acts_random();
        run_inference("busy_start", 1, 1);
        quiet("busy_start");

        set_acts_random();
        run_inference("pre_b2b", 0, 1);
        set_acts_random();
        run_inference("b2b", 0, 2);
        post_done("b2b");

        set_acts_random();
        run_inference("mid_reset", 2, 1);
        set_acts_random();
        run_inference("after_reset", 0, 1);
        post_done("after_reset");

        check("max_rd_addr", max_addr, ROWS-1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
